mips_alu_arbiter: RTL

MIPS_ALU_ARBITER -- requirements
Module: mips_alu_arbiter

---
 rtl/mips_alu_arbiter_if.sv | 54 +++++
 rtl/mips_alu_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mips_alu_arbiter_if.sv
// Bus bundle for the two-requester ALU arbiter: requester handshakes,
// the shared ALU drive/return lines and the response channel.
// slave  = arbiter side, master = environment (requesters, ALU, consumer).
interface mips_alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_r;
    logic             alu_z;
    logic             alu_v;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_z;
    logic             rsp_v;
    logic             rsp_cout;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_r, alu_z, alu_v, alu_cout,
        output rsp_valid, rsp_id, rsp_r, rsp_z, rsp_v, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_r, alu_z, alu_v, alu_cout,
        input  rsp_valid, rsp_id, rsp_r, rsp_z, rsp_v, rsp_cout,
        output rsp_ready
    );
endinterface

// File: rtl/mips_alu_arbiter.sv
// Two-port arbiter in front of a shared combinational MIPS ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC (ALU driven
// from latched operands, result captured) -> RESP (held until consumed).
// Build option: define MIPS_ALU_ARB_FIXED_PRIO_EN to make port 0 always win
// a tie; otherwise ties alternate round-robin starting with port 0.
module mips_alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mips_alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [1:0]       valid_vec;
    logic [1:0]       ready_vec;
    logic             grant;
    logic             accept;
    logic             rsp_valid_c;

    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             id_reg;

    logic [WIDTH-1:0] rsp_r_reg;
    logic             rsp_z_reg;
    logic             rsp_v_reg;
    logic             rsp_cout_reg;

    assign valid_vec = {bus.req1_valid, bus.req0_valid};

    // Nothing is accepted while reset is held, even though the state already reads IDLE.
    assign accept = (state_reg == IDLE) && (|valid_vec) && !reset;

`ifdef MIPS_ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 wins whenever it is valid.
    always_comb begin
        grant = 1'b0;
        if (!valid_vec[0] && valid_vec[1]) begin
            grant = 1'b1;
        end
    end
`else
    logic last_grant_reg;

    // Round-robin: on a tie grant the port that did not win last time.
    always_comb begin
        grant = 1'b0;
        if (valid_vec == 2'b11) begin
            grant = ~last_grant_reg;
        end else if (valid_vec[1]) begin
            grant = 1'b1;
        end
    end

    // Remember the winner of every accepted request; reset favours port 0 next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= grant;
        end
    end
`endif

    // Ready is combinational and one-hot: only the granted port, only on accept.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = accept && (grant == gi[0]);
        end
    endgenerate

    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];

    // Operand mux from the granted requester, consumed only on accept.
    always_comb begin
        sel_op = bus.req0_op;
        sel_a  = bus.req0_a;
        sel_b  = bus.req0_b;
        if (grant) begin
            sel_op = bus.req1_op;
            sel_a  = bus.req1_a;
            sel_b  = bus.req1_b;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and response-valid decode.
    always_comb begin
        state_next  = state_reg;
        rsp_valid_c = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the granted operation; these registers alone drive the ALU so its
    // inputs never follow requester lines between operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg <= 3'd0;
            a_reg  <= '0;
            b_reg  <= '0;
            id_reg <= 1'b0;
        end else if (accept) begin
            op_reg <= sel_op;
            a_reg  <= sel_a;
            b_reg  <= sel_b;
            id_reg <= grant;
        end
    end

    // Capture the ALU result and flags at the end of EXEC; held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_r_reg    <= '0;
            rsp_z_reg    <= 1'b0;
            rsp_v_reg    <= 1'b0;
            rsp_cout_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_r_reg    <= bus.alu_r;
            rsp_z_reg    <= bus.alu_z;
            rsp_v_reg    <= bus.alu_v;
            rsp_cout_reg <= bus.alu_cout;
        end
    end

    assign bus.alu_op    = op_reg;
    assign bus.alu_a     = a_reg;
    assign bus.alu_b     = b_reg;

    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_r     = rsp_r_reg;
    assign bus.rsp_z     = rsp_z_reg;
    assign bus.rsp_v     = rsp_v_reg;
    assign bus.rsp_cout  = rsp_cout_reg;

endmodule
